// File: rtl/carfield_clk_div_ctrl_pkg.sv
// carfield_clk_div_ctrl_pkg: domain count, divider types and defaults for the clock-enable controller
package carfield_clk_div_ctrl_pkg;

    localparam int unsigned CarfieldNumDomains = 6;
    localparam int unsigned CarfieldDivWidth   = 8;

    typedef enum int unsigned {
        PeriphDomain,
        SafedDomain,
        SecuredDomain,
        PulpDomain,
        SpatzDomain,
        L2Domain
    } carfield_domain_idx_e;

    typedef logic [CarfieldDivWidth-1:0] carfield_div_t;
    typedef carfield_div_t [CarfieldNumDomains-1:0] carfield_clk_div_values_t;

    localparam carfield_clk_div_values_t CarfieldClkDivValue = {CarfieldNumDomains{carfield_div_t'(1)}};

    typedef enum logic [1:0] {
        RUN,
        PEND,
        GATED
    } clk_div_state_e;

endpackage

// File: rtl/carfield_clk_div_ctrl_if.sv
// carfield_clk_div_ctrl_if: per-domain divider update handshake, gating and enable outputs
interface carfield_clk_div_ctrl_if
    import carfield_clk_div_ctrl_pkg::*;
#(
    parameter int unsigned NumDomains = CarfieldNumDomains,
    parameter int unsigned DivWidth   = CarfieldDivWidth
);
    logic [NumDomains-1:0]               div_valid;
    logic [NumDomains-1:0][DivWidth-1:0] div;
    logic [NumDomains-1:0]               div_ready;
    logic [NumDomains-1:0]               gate;
    logic [NumDomains-1:0]               clk_en;
    logic [NumDomains-1:0][DivWidth-1:0] cur_div;
    logic [NumDomains-1:0]               busy;

    modport master (output div_valid, div, gate, input div_ready, clk_en, cur_div, busy);
    modport slave  (input div_valid, div, gate, output div_ready, clk_en, cur_div, busy);
endinterface

// File: rtl/carfield_clk_div_unit.sv
// carfield_clk_div_unit: single-domain enable counter with boundary-aligned divider updates
module carfield_clk_div_unit
    import carfield_clk_div_ctrl_pkg::*;
#(
    parameter int unsigned          DivWidth   = CarfieldDivWidth,
    parameter logic [DivWidth-1:0]  DefaultDiv = DivWidth'(1)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                div_valid,
    input  logic [DivWidth-1:0] div,
    output logic                div_ready,
    input  logic                gate,
    output logic                clk_en,
    output logic [DivWidth-1:0] cur_div,
    output logic                busy
);
    clk_div_state_e      state;
    logic [DivWidth-1:0] cnt;
    logic [DivWidth-1:0] pend_div;
    logic                hs;
    logic                wrap;

    assign div_ready = (state != PEND) && !rst_i;
    assign hs        = div_valid && div_ready;
    assign wrap      = (cur_div != '0) && (cnt == cur_div - DivWidth'(1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= RUN;
            cnt      <= '0;
            cur_div  <= DefaultDiv;
            pend_div <= '0;
            clk_en   <= 1'b0;
            busy     <= 1'b0;
        end else begin
            clk_en <= 1'b0;
            // gated or leaving gate: flush any pending divider, accept new ones for the next cycle
            if (gate || state == GATED) begin
                state <= gate ? GATED : (hs ? PEND : RUN);
                cnt   <= '0;
                busy  <= hs;
                if (busy) cur_div <= pend_div;
                if (hs) pend_div <= div;
            end else if (state == PEND) begin
                if (cur_div == '0 || wrap) begin
                    clk_en  <= wrap;
                    cur_div <= pend_div;
                    cnt     <= '0;
                    state   <= RUN;
                    busy    <= 1'b0;
                end else begin
                    cnt <= cnt + DivWidth'(1);
                end
            end else begin
                if (wrap) begin
                    cnt    <= '0;
                    clk_en <= 1'b1;
                end else if (cur_div != '0) begin
                    cnt <= cnt + DivWidth'(1);
                end
                if (hs) begin
                    pend_div <= div;
                    state    <= PEND;
                    busy     <= 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/carfield_clk_div_ctrl.sv
// carfield_clk_div_ctrl: one independent clock-enable divider per island domain
module carfield_clk_div_ctrl
    import carfield_clk_div_ctrl_pkg::*;
#(
    parameter int unsigned                         NumDomains = CarfieldNumDomains,
    parameter int unsigned                         DivWidth   = CarfieldDivWidth,
    parameter logic [NumDomains-1:0][DivWidth-1:0] DefaultDiv = CarfieldClkDivValue
) (
    input logic                     clk_i,
    input logic                     rst_i,
    carfield_clk_div_ctrl_if.slave  bus
);
    for (genvar d = 0; d < NumDomains; d++) begin : g_dom
        carfield_clk_div_unit #(
            .DivWidth   (DivWidth),
            .DefaultDiv (DefaultDiv[d])
        ) u_unit (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .div_valid (bus.div_valid[d]),
            .div       (bus.div[d]),
            .div_ready (bus.div_ready[d]),
            .gate      (bus.gate[d]),
            .clk_en    (bus.clk_en[d]),
            .cur_div   (bus.cur_div[d]),
            .busy      (bus.busy[d])
        );
    end
endmodule
